// File: rtl/uart_rx_frame_check_pkg.sv
// Shared UART definitions: parity-type encoding (common with the TX parity
// generator), receive FSM states and the default word width.
package uart_rx_frame_check_pkg;

   localparam int unsigned DEFAULT_DATA_WIDTH = 16;

   localparam logic PAR_EVEN = 1'b1;
   localparam logic PAR_ODD  = 1'b0;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PARITY,
      STOP
   } rx_state_t;

endpackage

// File: rtl/uart_rx_frame_check_if.sv
// Sampler-side bit stream, frame config and the parallel result bus of the
// RX frame checker. master = sampler/controller side, slave = checker.
interface uart_rx_frame_check_if
   import uart_rx_frame_check_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
);
   logic                  sampled_bit;
   logic                  bit_strobe;
   logic                  PAR_EN;
   logic                  PAR_TYP;
   logic [DATA_WIDTH-1:0] P_DATA;
   logic                  data_valid;
   logic                  par_err;
   logic                  stp_err;
   logic                  busy;

   modport master (
      output sampled_bit, bit_strobe, PAR_EN, PAR_TYP,
      input  P_DATA, data_valid, par_err, stp_err, busy
   );

   modport slave (
      input  sampled_bit, bit_strobe, PAR_EN, PAR_TYP,
      output P_DATA, data_valid, par_err, stp_err, busy
   );
endinterface

// File: rtl/uart_rx_deser.sv
// Data-bit deserializer: LSB-first shift register, bit counter and running
// parity, all sequenced by clear/shift enables from the frame FSM.
module uart_rx_deser #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned CNT_WIDTH  = $clog2(DATA_WIDTH + 1)
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  clear,
   input  logic                  shift,
   input  logic                  bit_in,
   output logic [DATA_WIDTH-1:0] shreg,
   output logic [CNT_WIDTH-1:0]  count,
   output logic                  parity
);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         shreg  <= '0;
         count  <= '0;
         parity <= 1'b0;
      end else if (clear) begin
         shreg  <= '0;
         count  <= '0;
         parity <= 1'b0;
      end else if (shift) begin
         // shifting in at the MSB end leaves the first bit in shreg[0]
         shreg  <= {bit_in, shreg[DATA_WIDTH-1:1]};
         count  <= count + 1'b1;
         parity <= parity ^ bit_in;
      end
   end

endmodule

// File: rtl/uart_rx_frame_check.sv
// UART receive frame checker: start/data/parity/stop sequencing, parity and
// stop checking, and registered result pulses towards the RX FIFO side.
module uart_rx_frame_check
   import uart_rx_frame_check_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic                   CLK,
   input  logic                   RST,
   uart_rx_frame_check_if.slave   bus
);

   localparam int unsigned CNT_WIDTH = $clog2(DATA_WIDTH + 1);
   localparam logic [CNT_WIDTH-1:0] LAST_BIT = CNT_WIDTH'(DATA_WIDTH - 1);

   rx_state_t             state_q, state_d;
   logic                  par_en_q, par_typ_q;
   logic                  par_bad_q, par_bad_d;
   logic                  clear, shift, latch_cfg;
   logic                  load, pe_set, se_set;
   logic [DATA_WIDTH-1:0] shreg;
   logic [CNT_WIDTH-1:0]  count;
   logic                  parity;

   uart_rx_deser #(
      .DATA_WIDTH (DATA_WIDTH),
      .CNT_WIDTH  (CNT_WIDTH)
   ) u_deser (
      .CLK    (CLK),
      .RST    (RST),
      .clear  (clear),
      .shift  (shift),
      .bit_in (bus.sampled_bit),
      .shreg  (shreg),
      .count  (count),
      .parity (parity)
   );

   always_comb begin
      state_d   = state_q;
      par_bad_d = par_bad_q;
      clear     = 1'b0;
      shift     = 1'b0;
      latch_cfg = 1'b0;
      load      = 1'b0;
      pe_set    = 1'b0;
      se_set    = 1'b0;
      if (bus.bit_strobe) begin
         unique case (state_q)
            IDLE: if (!bus.sampled_bit) begin
               clear     = 1'b1;
               latch_cfg = 1'b1;
               par_bad_d = 1'b0;
               state_d   = DATA;
            end
            DATA: begin
               shift = 1'b1;
               if (count == LAST_BIT)
                  state_d = par_en_q ? PARITY : STOP;
            end
            PARITY: begin
               // expected bit is data XOR for even, its inverse for odd
               par_bad_d = bus.sampled_bit ^ (parity ^ (par_typ_q == PAR_ODD));
               state_d   = STOP;
            end
            STOP: begin
               se_set  = !bus.sampled_bit;
               pe_set  = par_bad_q;
               load    = bus.sampled_bit && !par_bad_q;
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q        <= IDLE;
         par_en_q       <= 1'b0;
         par_typ_q      <= 1'b0;
         par_bad_q      <= 1'b0;
         bus.P_DATA     <= '0;
         bus.data_valid <= 1'b0;
         bus.par_err    <= 1'b0;
         bus.stp_err    <= 1'b0;
         bus.busy       <= 1'b0;
      end else begin
         state_q        <= state_d;
         par_bad_q      <= par_bad_d;
         if (latch_cfg) begin
            par_en_q  <= bus.PAR_EN;
            par_typ_q <= bus.PAR_TYP;
         end
         if (load)
            bus.P_DATA <= shreg;
         bus.data_valid <= load;
         bus.par_err    <= pe_set;
         bus.stp_err    <= se_set;
         bus.busy       <= (state_d != IDLE);
      end
   end

endmodule

// File: tb/tb_uart_rx_frame_check.sv
// Directed and randomized frames against a word-level reference of the
// UART frame rules (parity from popcount, stop/parity error gating).
module tb_uart_rx_frame_check;
   import uart_rx_frame_check_pkg::*;

   localparam int unsigned DW = DEFAULT_DATA_WIDTH;

   logic CLK = 1'b0;
   logic RST;
   always #5 CLK = ~CLK;

   uart_rx_frame_check_if #(.DATA_WIDTH(DW)) bus ();

   uart_rx_frame_check #(.DATA_WIDTH(DW)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   int errors = 0;
   int checks = 0;
   logic [DW-1:0] model_pdata = '0;

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic send_bit(input logic b);
      bus.sampled_bit = b;
      bus.bit_strobe  = 1'b1;
      step();
      bus.bit_strobe  = 1'b0;
      bus.sampled_bit = 1'($urandom);
   endtask

   task automatic gap(input int unsigned maxgap);
      repeat ($urandom_range(maxgap, 0)) step();
   endtask

   // Parity bit a correct transmitter would send for this word.
   function automatic logic good_par(input logic [DW-1:0] d, input logic ptyp);
      logic odd_ones;
      odd_ones = ($countones(d) % 2) == 1;
      return (ptyp == PAR_EVEN) ? odd_ones : !odd_ones;
   endfunction

   task automatic send_frame(input logic [DW-1:0] data, input logic pen, input logic ptyp,
                             input logic pbit, input logic sbit, input int unsigned maxgap,
                             input logic toggle, input logic chk_after);
      logic exp_pe, exp_se, exp_dv;
      bus.PAR_EN  = pen;
      bus.PAR_TYP = ptyp;
      send_bit(1'b0);
      check("busy_after_start", DW'(bus.busy), DW'(1));
      check("dv_after_start", DW'(bus.data_valid), DW'(0));
      if (toggle) begin
         bus.PAR_EN  = ~pen;
         bus.PAR_TYP = ~ptyp;
      end
      for (int i = 0; i < int'(DW); i++) begin
         gap(maxgap);
         send_bit(data[i]);
      end
      if (pen) begin
         gap(maxgap);
         send_bit(pbit);
      end
      check("busy_before_stop", DW'(bus.busy), DW'(1));
      gap(maxgap);
      send_bit(sbit);
      exp_pe = pen && (pbit != good_par(data, ptyp));
      exp_se = !sbit;
      exp_dv = !exp_pe && !exp_se;
      if (exp_dv) model_pdata = data;
      check("data_valid", DW'(bus.data_valid), DW'(exp_dv));
      check("par_err", DW'(bus.par_err), DW'(exp_pe));
      check("stp_err", DW'(bus.stp_err), DW'(exp_se));
      check("busy_at_result", DW'(bus.busy), DW'(0));
      check("P_DATA", bus.P_DATA, model_pdata);
      if (chk_after) begin
         step();
         check("pulses_one_cycle", DW'({bus.data_valid, bus.par_err, bus.stp_err}), DW'(0));
      end
   endtask

   initial begin
      logic [DW-1:0] d;
      logic pen, ptyp, pbit, sbit;

      RST             = 1'b0;
      bus.sampled_bit = 1'b1;
      bus.bit_strobe  = 1'b0;
      bus.PAR_EN      = 1'b0;
      bus.PAR_TYP     = 1'b0;
      step();
      check("rst_P_DATA", bus.P_DATA, '0);
      check("rst_flags", DW'({bus.data_valid, bus.par_err, bus.stp_err, bus.busy}), DW'(0));
      RST = 1'b1;
      step();

      // Directed frames
      send_frame(16'hA5C3, 1'b1, PAR_EVEN, 1'b0, 1'b1, 0, 1'b0, 1'b1);
      send_frame(16'hA5C3, 1'b1, PAR_EVEN, 1'b1, 1'b1, 1, 1'b0, 1'b1);
      send_frame(16'h0001, 1'b1, PAR_ODD,  1'b0, 1'b0, 1, 1'b0, 1'b1);
      send_frame(16'hFFFF, 1'b0, PAR_EVEN, 1'b0, 1'b1, 0, 1'b0, 1'b0);
      send_frame(16'h1234, 1'b0, PAR_EVEN, 1'b0, 1'b1, 0, 1'b0, 1'b1);

      // Idle strobes with the line high must not start a frame
      repeat (4) begin
         send_bit(1'b1);
         check("idle_strobe_busy", DW'(bus.busy), DW'(0));
      end
      // Config flipped right after the start bit: latched odd parity governs
      send_frame(16'h00F7, 1'b1, PAR_ODD, good_par(16'h00F7, PAR_ODD), 1'b1, 2, 1'b1, 1'b1);
      send_frame(16'h5A5A, 1'b0, PAR_EVEN, 1'b0, 1'b1, 2, 1'b1, 1'b1);

      // Reset after 5 data bits discards the frame at once
      bus.PAR_EN = 1'b1;
      send_bit(1'b0);
      for (int i = 0; i < 5; i++) send_bit(1'($urandom));
      RST = 1'b0;
      #1;
      model_pdata = '0;
      check("midrst_busy", DW'(bus.busy), DW'(0));
      check("midrst_P_DATA", bus.P_DATA, model_pdata);
      check("midrst_flags", DW'({bus.data_valid, bus.par_err, bus.stp_err}), DW'(0));
      step();
      RST = 1'b1;
      step();
      send_frame(16'hC0DE, 1'b1, PAR_EVEN, good_par(16'hC0DE, PAR_EVEN), 1'b1, 1, 1'b0, 1'b1);

      // Randomized frames, mostly well-formed
      for (int n = 0; n < 24; n++) begin
         d    = DW'($urandom);
         pen  = 1'($urandom);
         ptyp = 1'($urandom);
         pbit = ($urandom_range(3, 0) == 0) ? !good_par(d, ptyp) : good_par(d, ptyp);
         sbit = ($urandom_range(4, 0) != 0);
         send_frame(d, pen, ptyp, pbit, sbit, 2, 1'($urandom), 1'($urandom));
      end

      step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
